mux_a_pipe: RTL and testbench

//  Parametrised, registered successor to the accumulator-A input selector.

---
 rtl/mux_a_pipe_if.sv | 34 +++
 rtl/mux_a_pipe.sv | 74 +++++++
 tb/tb_mux_a_pipe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mux_a_pipe_if.sv
// Handshake bundle between the datapath sources and the accumulator-A
// load port: source vector, select, valid/ready in both directions, the
// sticky select-error flag and the transfer counter.
interface mux_a_pipe_if #(
   parameter int WIDTH = 11,
   parameter int N_SRC = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 8
) ();

   logic [N_SRC*WIDTH-1:0] src_in;
   logic [SEL_W-1:0]       sel_A;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       mux_A_out;
   logic                   out_valid;
   logic                   out_ready;
   logic                   sel_err;
   logic                   err_clr;
   logic [CNT_W-1:0]       xfer_cnt;

   // Upstream/downstream side: drives sources, select and the handshakes.
   modport master (
      output src_in, sel_A, in_valid, out_ready, err_clr,
      input  in_ready, mux_A_out, out_valid, sel_err, xfer_cnt
   );

   // Selector side: the mux_a_pipe block itself.
   modport slave (
      input  src_in, sel_A, in_valid, out_ready, err_clr,
      output in_ready, mux_A_out, out_valid, sel_err, xfer_cnt
   );

endinterface

// File: rtl/mux_a_pipe.sv
// Registered accumulator-A input selector. Picks one of N_SRC sources on an
// accepted transfer and holds it in a one-entry output register with a
// valid/ready handshake. Out-of-range selects load zero and raise a sticky
// error; every accepted transfer bumps a wrapping counter.
module mux_a_pipe #(
   parameter int WIDTH = 11,
   parameter int N_SRC = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 8
) (
   input  logic        clock,
   input  logic        reset,
   mux_a_pipe_if.slave bus
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] sel_data;
   logic             sel_bad;
   logic             accept;

   // Ready whenever the register is empty or being drained this cycle.
   assign bus.in_ready  = !valid_q || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;

   assign bus.mux_A_out = data_q;
   assign bus.out_valid = valid_q;
   assign bus.sel_err   = err_q;
   assign bus.xfer_cnt  = cnt_q;

   // Decode the select into channel data; unmatched selects yield zero.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      sel_data = '0;
      sel_bad  = 1'b1;
      for (int k = 0; k < N_SRC; k++) begin
         if (bus.sel_A == SEL_W'(k)) begin
            sel_data = bus.src_in[k*WIDTH +: WIDTH];
            sel_bad  = 1'b0;
         end
      end
   end

   // Output register, handshake state, sticky error and transfer counter.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            data_q  <= sel_data;
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
         end else if (bus.out_ready) begin
            // Drained with nothing behind it; data stays for observability.
            valid_q <= 1'b0;
         end

         // A new error on this cycle wins over a simultaneous clear.
         if (accept && sel_bad) begin
            err_q <= 1'b1;
         end else if (bus.err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_a_pipe.sv
// Scoreboard bench for mux_a_pipe. A stimulus process drives directed and
// random transfers and pushes each accepted word into an expected queue; a
// separate monitor compares the DUT against that queue on every falling edge.
module tb_mux_a_pipe;

   localparam int WIDTH = 11;
   localparam int N_SRC = 3;
   localparam int SEL_W = 2;
   localparam int CNT_W = 2;

   logic clock;
   logic reset;

   mux_a_pipe_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

   mux_a_pipe #(.WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state
   logic [WIDTH-1:0] src [N_SRC];
   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] m_hold;
   logic [CNT_W-1:0] m_cnt;
   logic             m_err;
   logic             exp_ready;
   logic             m_accept;
   logic             mon_en;

   int n_checks;
   int n_errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock cycle of stimulus; called just after a rising edge.
   task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic ordy,
                       input logic clr, input logic rst);
      logic [WIDTH-1:0] word;
      reset         = rst;
      bus.in_valid  = v;
      bus.sel_A     = s;
      bus.out_ready = ordy;
      bus.err_clr   = clr;
      for (int k = 0; k < N_SRC; k++) bus.src_in[k*WIDTH +: WIDTH] = src[k];

      exp_ready = (exp_q.size() == 0) || ordy;
      m_accept  = v && exp_ready;
      if (int'(s) < N_SRC) word = src[s];
      else                 word = '0;

      @(posedge clock);
      if (rst) begin
         exp_q.delete();
         m_cnt  = '0;
         m_err  = 1'b0;
         m_hold = '0;
      end else begin
         if (m_accept) begin
            exp_q.push_back(word);
            m_cnt = m_cnt + 1'b1;
         end
         if (m_accept && int'(s) >= N_SRC) m_err = 1'b1;
         else if (clr)                     m_err = 1'b0;
      end
      #1;
   endtask

   // Monitor: compare outputs against the model away from the rising edge.
   initial begin
      forever begin
         @(negedge clock);
         if (mon_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               check("mux_A_out", 32'(bus.mux_A_out), 32'(exp_q[0]));
               if (bus.out_ready) m_hold = exp_q.pop_front();
            end else begin
               check("mux_A_out_hold", 32'(bus.mux_A_out), 32'(m_hold));
            end
            check("sel_err", 32'(bus.sel_err), 32'(m_err));
            check("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic             v, ordy, clr, rst;
      logic [SEL_W-1:0] s;
      logic             held;

      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      m_hold   = '0;
      m_cnt    = '0;
      m_err    = 1'b0;
      exp_ready = 1'b1;
      src[0] = 11'h782;
      src[1] = 11'h071;
      src[2] = 11'h000;

      @(posedge clock);
      #1;
      step(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
      mon_en = 1'b1;
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

      // Scenario 1: single accept of channel 1
      step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      // Scenario 2: back-to-back stream 0,1,2,0
      step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 2'd2, 1'b1, 1'b0, 1'b0);

      // Scenario 3: backpressure, source changes while blocked
      step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      src[0] = 11'h2AA;
      step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

      // Scenario 4: out-of-range select, clear, clear-vs-set priority
      step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
      step(1'b0, 2'd3, 1'b1, 1'b0, 1'b0);

      // Scenario 6: reset while full
      step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      src[0] = 11'h782;
      step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

      // Random phase; a blocked request is held stable until accepted.
      held = 1'b0;
      v = 1'b0; s = '0; ordy = 1'b1; clr = 1'b0; rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!held) begin
            v = ($urandom % 4) != 0;
            s = SEL_W'($urandom % 4);
            for (int k = 0; k < N_SRC; k++) src[k] = WIDTH'($urandom);
         end
         ordy = ($urandom % 3) != 0;
         clr  = ($urandom % 8) == 0;
         rst  = ($urandom % 64) == 0;
         step(v, s, ordy, clr, rst);
         held = v && !m_accept && !rst;
      end

      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
